opb_register_bank: RTL

OPB_REGISTER_BANK -- requirements
Module: opb_register_bank

---
 rtl/opb_reg_pkg.sv | 32 +++
 rtl/opb_reg_slave_if.sv | 94 +++++++++
 rtl/opb_register_bank.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/opb_reg_pkg.sv
// Shared definitions for the OPB register bank: the control-word location, the
// control-word bit positions, the ack FSM state type and the byte-lane merge helper.
package opb_reg_pkg;

    // Byte offset of the control word inside the decoded window, and its word index.
    localparam int unsigned CtrlOffset  = 32'h0000_00FC;
    localparam int unsigned CtrlWordIdx = CtrlOffset / 4;

    // Control-word bit positions, in user (descending) numbering.
    localparam int unsigned PendingBit = 31;
    localparam int unsigned CommitBit  = 0;

    typedef enum logic {
        StIdle,
        StAck
    } ack_state_e;

    // Lane k covers OPB data bits [8k:8k+7], which are user bits [31-8k:24-8k].
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  lanes);
        logic [31:0] res;
        res = old_val;
        for (int k = 0; k < 4; k++) begin
            if (lanes[k]) begin
                res[31-8*k -: 8] = new_val[31-8*k -: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/opb_reg_slave_if.sv
// OPB slave front end: address window decode, two-state ack FSM and the Sl_DBus /
// Sl_xferAck drivers. The register array lives in the parent; this block tells it
// when a transfer is accepted and which word is addressed, and returns its read data.
//
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   addr_i             byte address (numeric order, MSB left)
//   rnw_i, select_i    OPB read-not-write and select
//   req_o              transfer accepted this cycle (edge entering the ack state)
//   wr_o               accepted transfer is a write
//   reg_hit_o          accepted address maps to a register
//   ctrl_hit_o         accepted address is the control word
//   reg_idx_o          register index (valid with reg_hit_o)
//   rd_data_i          read data for the currently decoded address
//   sl_dbus_o          read data bus, zero outside the ack cycle
//   xfer_ack_o         transfer acknowledge
module opb_reg_slave_if
    import opb_reg_pkg::*;
#(
    parameter int unsigned          AddrWidth = 32,
    parameter logic [AddrWidth-1:0] BaseAddr  = 32'h0100_0C00,
    parameter logic [AddrWidth-1:0] HighAddr  = 32'h0100_0CFF,
    parameter int unsigned          NumRegs   = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [AddrWidth-1:0] addr_i,
    input  logic                 rnw_i,
    input  logic                 select_i,
    output logic                 req_o,
    output logic                 wr_o,
    output logic                 reg_hit_o,
    output logic                 ctrl_hit_o,
    output logic [5:0]           reg_idx_o,
    input  logic [31:0]          rd_data_i,
    output logic [31:0]          sl_dbus_o,
    output logic                 xfer_ack_o
);

    localparam logic [AddrWidth-3:0] NumRegsW  = (AddrWidth-2)'(NumRegs);
    localparam logic [AddrWidth-3:0] CtrlWordW = (AddrWidth-2)'(CtrlWordIdx);

    ack_state_e state_q, state_d;
    logic [31:0] rd_data_q, rd_data_d;

    logic [AddrWidth-1:0] offset;
    logic [AddrWidth-3:0] word;
    logic                 in_window;
    logic [1:0]           unused_offset;

    assign offset        = addr_i - BaseAddr;
    assign word          = offset[AddrWidth-1:2];
    assign unused_offset = offset[1:0];
    assign in_window     = (addr_i >= BaseAddr) && (addr_i <= HighAddr);

    assign reg_hit_o  = word < NumRegsW;
    assign ctrl_hit_o = word == CtrlWordW;
    assign reg_idx_o  = offset[7:2];

    always_comb begin
        state_d = state_q;
        req_o   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (select_i && in_window) begin
                    state_d = StAck;
                    req_o   = 1'b1;
                end
            end
            StAck:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign wr_o = req_o && !rnw_i;

    // Read data is captured on the edge entering ack and cleared otherwise, so the
    // bus is zero in every cycle that is not an ack.
    assign rd_data_d = (req_o && rnw_i) ? rd_data_i : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign xfer_ack_o = (state_q == StAck);
    assign sl_dbus_o  = xfer_ack_o ? rd_data_q : '0;

endmodule

// File: rtl/opb_register_bank.sv
// OPB slave register bank: C_NUM_REGS 32-bit user registers at C_BASEADDR+4i and a
// control word at C_BASEADDR+0xFC (register count in [7:0], pending flag in bit 31).
//
// Build option: define OPB_REG_BANK_SHADOW_EN to stage writes in shadow registers;
// a control-word write with lane 3 enabled and bit 0 set then copies every shadow
// to the user outputs at once. Without it, writes go straight to the user outputs.
//
// Ports:
//   OPB_Clk, OPB_Rst_n          clock, asynchronous active-low reset
//   OPB_ABus/BE/DBus/RNW/select OPB slave request (OPB_seqAddr is ignored)
//   Sl_DBus, Sl_xferAck         read data and acknowledge
//   Sl_errAck/retry/toutSup     tied low
//   user_data_out               register i at bits [32i+31:32i]
//   user_wr_stb                 one-cycle pulse per register on each user update
module opb_register_bank
    import opb_reg_pkg::*;
#(
    parameter int unsigned             C_OPB_AWIDTH  = 32,
    parameter logic [C_OPB_AWIDTH-1:0] C_BASEADDR    = 32'h0100_0C00,
    parameter logic [C_OPB_AWIDTH-1:0] C_HIGHADDR    = 32'h0100_0CFF,
    parameter int unsigned             C_OPB_DWIDTH  = 32,
    parameter int unsigned             C_NUM_REGS    = 8,
    parameter logic [31:0]             C_RESET_VALUE = 32'h0
) (
    input  logic                      OPB_Clk,
    input  logic                      OPB_Rst_n,
    input  logic [0:C_OPB_AWIDTH-1]   OPB_ABus,
    input  logic [0:3]                OPB_BE,
    input  logic [0:31]               OPB_DBus,
    input  logic                      OPB_RNW,
    input  logic                      OPB_select,
    input  logic                      OPB_seqAddr,
    output logic [0:31]               Sl_DBus,
    output logic                      Sl_xferAck,
    output logic                      Sl_errAck,
    output logic                      Sl_retry,
    output logic                      Sl_toutSup,
    output logic [C_NUM_REGS*32-1:0]  user_data_out,
    output logic [C_NUM_REGS-1:0]     user_wr_stb
);

    logic [C_OPB_AWIDTH-1:0] addr;
    logic [31:0]             wdata;
    logic [3:0]              lanes;
    logic                    req, wr, reg_hit, ctrl_hit;
    logic [5:0]              reg_idx;
    logic [31:0]             rd_data, sl_dbus;
    logic                    pending;
    logic                    unused_ok;

    logic [31:0]           user_q [C_NUM_REGS];
    logic [31:0]           user_d [C_NUM_REGS];
    logic [C_NUM_REGS-1:0] stb_q, stb_d;

    // OPB numbers bits ascending from the MSB; a plain assignment keeps the MSB on
    // the left, so user bit 31 is OPB bit 0.
    assign addr  = OPB_ABus;
    assign wdata = OPB_DBus;
    always_comb begin
        lanes = '0;
        for (int k = 0; k < 4; k++) begin
            lanes[k] = OPB_BE[k];
        end
    end

    assign unused_ok = OPB_seqAddr ^ (C_OPB_DWIDTH != 32);

    opb_reg_slave_if #(
        .AddrWidth (C_OPB_AWIDTH),
        .BaseAddr  (C_BASEADDR),
        .HighAddr  (C_HIGHADDR),
        .NumRegs   (C_NUM_REGS)
    ) u_slave_if (
        .clk_i      (OPB_Clk),
        .rst_ni     (OPB_Rst_n),
        .addr_i     (addr),
        .rnw_i      (OPB_RNW),
        .select_i   (OPB_select),
        .req_o      (req),
        .wr_o       (wr),
        .reg_hit_o  (reg_hit),
        .ctrl_hit_o (ctrl_hit),
        .reg_idx_o  (reg_idx),
        .rd_data_i  (rd_data),
        .sl_dbus_o  (sl_dbus),
        .xfer_ack_o (Sl_xferAck)
    );

    assign Sl_DBus    = sl_dbus;
    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;

`ifdef OPB_REG_BANK_SHADOW_EN
    logic [31:0] shadow_q [C_NUM_REGS];
    logic [31:0] shadow_d [C_NUM_REGS];
    logic        pending_q, pending_d;

    always_comb begin
        user_d    = user_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        stb_d     = '0;
        for (int i = 0; i < C_NUM_REGS; i++) begin
            if (wr && reg_hit && (reg_idx == 6'(i))) begin
                shadow_d[i] = merge_lanes(shadow_q[i], wdata, lanes);
                pending_d   = 1'b1;
            end
        end
        if (wr && ctrl_hit && lanes[3] && wdata[CommitBit]) begin
            user_d    = shadow_q;
            stb_d     = '1;
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            for (int i = 0; i < C_NUM_REGS; i++) begin
                shadow_q[i] <= C_RESET_VALUE;
            end
            pending_q <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
        end
    end

    assign pending = pending_q;
`else
    always_comb begin
        user_d = user_q;
        stb_d  = '0;
        for (int i = 0; i < C_NUM_REGS; i++) begin
            if (wr && reg_hit && (reg_idx == 6'(i))) begin
                user_d[i] = merge_lanes(user_q[i], wdata, lanes);
                stb_d[i]  = 1'b1;
            end
        end
    end

    assign pending = 1'b0;
`endif

    // Read mux; reads return the shadow copy when staging is enabled.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < C_NUM_REGS; i++) begin
            if (reg_hit && (reg_idx == 6'(i))) begin
`ifdef OPB_REG_BANK_SHADOW_EN
                rd_data = shadow_q[i];
`else
                rd_data = user_q[i];
`endif
            end
        end
        if (ctrl_hit) begin
            rd_data                      = 32'(C_NUM_REGS[7:0]);
            rd_data[PendingBit]          = pending;
        end
    end

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            for (int i = 0; i < C_NUM_REGS; i++) begin
                user_q[i] <= C_RESET_VALUE;
            end
            stb_q <= '0;
        end else begin
            user_q <= user_d;
            stb_q  <= stb_d;
        end
    end

    always_comb begin
        user_data_out = '0;
        for (int i = 0; i < C_NUM_REGS; i++) begin
            user_data_out[32*i +: 32] = user_q[i];
        end
    end

    assign user_wr_stb = stb_q;

endmodule
